// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - opcode constants and shared types for the MEM/WB stage
package mem_wb_stage_pkg;

    localparam int DM_AW_DEFAULT = 12;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_BYTE = 2'd1,
        ACC_HALF = 2'd2,
        ACC_WORD = 2'd3
    } access_t;

endpackage

// File: rtl/mem_wb_stage_dm_ram.sv
// rtl/mem_wb_stage_dm_ram.sv - word-organised data memory with byte enables and clear-on-reset
module dm_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    // Reads are combinational so a load can extract its lane within the MEM cycle.
    assign rdata = mem[widx];

    // Reset wipes every word and wins over any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage load/store execution and MEM/WB pipeline register
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrMEM,
    input  logic [31:0] aluOutMEM,
    input  logic [31:0] rtdataMEM,
    input  logic [31:0] pcMEM,
    input  logic        RegWriteMEM,
    input  logic [4:0]  RegAddrMEM,
    input  logic [31:0] RegDataMEM,
    output logic [31:0] instrWB,
    output logic [31:0] pcWB,
    output logic        RegWriteWB,
    output logic [4:0]  RegAddrWB,
    output logic [31:0] RegDataWB,
    output logic        addrExcWB
);

    logic [5:0]       opcode;
    logic [1:0]       lane;
    logic [DM_AW-1:0] widx;
    access_t          acc;
    logic             is_load;
    logic             is_store;
    logic             sign_ext;
    logic             misaligned;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic [31:0]      shifted;
    logic [31:0]      load_data;
    logic [31:0]      wb_data;
    logic             unused_addr_bits;

    assign opcode = instrMEM[31:26];
    assign lane   = aluOutMEM[1:0];
    assign widx   = aluOutMEM[DM_AW+1:2];

    // Address bits above the memory window are ignored so accesses wrap.
    assign unused_addr_bits = ^aluOutMEM[31:DM_AW+2];

    // Decode access width, direction and extension from the opcode.
    always_comb begin
        acc      = ACC_NONE;
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        case (opcode)
            OP_LW:  begin acc = ACC_WORD; is_load  = 1'b1; end
            OP_LH:  begin acc = ACC_HALF; is_load  = 1'b1; sign_ext = 1'b1; end
            OP_LHU: begin acc = ACC_HALF; is_load  = 1'b1; end
            OP_LB:  begin acc = ACC_BYTE; is_load  = 1'b1; sign_ext = 1'b1; end
            OP_LBU: begin acc = ACC_BYTE; is_load  = 1'b1; end
            OP_SW:  begin acc = ACC_WORD; is_store = 1'b1; end
            OP_SH:  begin acc = ACC_HALF; is_store = 1'b1; end
            OP_SB:  begin acc = ACC_BYTE; is_store = 1'b1; end
            default: ;
        endcase
    end

    // Words need lane 0, halves need an even lane; bytes are always aligned.
    always_comb begin
        misaligned = 1'b0;
        if (acc == ACC_WORD && lane != 2'd0) misaligned = 1'b1;
        if (acc == ACC_HALF && lane[0])      misaligned = 1'b1;
    end

    // Build byte enables and replicate store data onto every lane it may land in.
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = rtdataMEM;
        case (acc)
            ACC_BYTE: begin
                mem_be    = 4'b0001 << lane;
                mem_wdata = {4{rtdataMEM[7:0]}};
            end
            ACC_HALF: begin
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{rtdataMEM[15:0]}};
            end
            ACC_WORD: mem_be = 4'b1111;
            default: ;
        endcase
    end

    assign mem_we = is_store && !misaligned;

    dm_ram #(.AW(DM_AW)) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .be    (mem_be),
        .widx  (widx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign shifted = mem_rdata >> {lane, 3'b000};

    // Extract the addressed byte/half and extend it; misaligned loads return zero.
    always_comb begin
        load_data = '0;
        case (acc)
            ACC_BYTE: load_data = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'h0, shifted[7:0]};
            ACC_HALF: load_data = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'h0, shifted[15:0]};
            ACC_WORD: load_data = mem_rdata;
            default: ;
        endcase
        if (misaligned) load_data = '0;
    end

    // Loads write back memory data; everything else forwards the EX result.
    always_comb begin
        wb_data = RegDataMEM;
        if (is_load) wb_data = load_data;
    end

    // MEM/WB boundary register with the register-0 write guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrWB    <= '0;
            pcWB       <= '0;
            RegWriteWB <= 1'b0;
            RegAddrWB  <= '0;
            RegDataWB  <= '0;
            addrExcWB  <= 1'b0;
        end else begin
            instrWB    <= instrMEM;
            pcWB       <= pcMEM;
            RegWriteWB <= RegWriteMEM && (RegAddrMEM != 5'd0);
            RegAddrWB  <= RegAddrMEM;
            RegDataWB  <= wb_data;
            addrExcWB  <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a byte-level memory model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrMEM = '0;
    logic [31:0] aluOutMEM = '0;
    logic [31:0] rtdataMEM = '0;
    logic [31:0] pcMEM = '0;
    logic        RegWriteMEM = 1'b0;
    logic [4:0]  RegAddrMEM = '0;
    logic [31:0] RegDataMEM = '0;
    logic [31:0] instrWB;
    logic [31:0] pcWB;
    logic        RegWriteWB;
    logic [4:0]  RegAddrWB;
    logic [31:0] RegDataWB;
    logic        addrExcWB;

    int errors = 0;
    int checks = 0;

    // Little-endian byte image of the 16 KiB data memory.
    logic [7:0] ref_mem [0:16383];

    mem_wb_stage #(.DM_AW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .instrMEM    (instrMEM),
        .aluOutMEM   (aluOutMEM),
        .rtdataMEM   (rtdataMEM),
        .pcMEM       (pcMEM),
        .RegWriteMEM (RegWriteMEM),
        .RegAddrMEM  (RegAddrMEM),
        .RegDataMEM  (RegDataMEM),
        .instrWB     (instrWB),
        .pcWB        (pcWB),
        .RegWriteWB  (RegWriteWB),
        .RegAddrWB   (RegAddrWB),
        .RegDataWB   (RegDataWB),
        .addrExcWB   (addrExcWB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [31:0] r;
        r = $urandom;
        return {op, r[25:0]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
    endtask

    // One instruction through MEM; the model predicts the WB register contents.
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] pc, input logic rw,
                        input logic [4:0] ra, input logic [31:0] rd);
        logic [5:0]  op;
        logic [13:0] a;
        int          size;
        bit          ld, st, sx, exc;
        logic [31:0] val, raw;
        op = instr[31:26];
        a  = addr[13:0];
        size = 0; ld = 0; st = 0; sx = 0;
        case (op)
            6'h23: begin size = 4; ld = 1; end
            6'h21: begin size = 2; ld = 1; sx = 1; end
            6'h25: begin size = 2; ld = 1; end
            6'h20: begin size = 1; ld = 1; sx = 1; end
            6'h24: begin size = 1; ld = 1; end
            6'h2B: begin size = 4; st = 1; end
            6'h29: begin size = 2; st = 1; end
            6'h28: begin size = 1; st = 1; end
            default: ;
        endcase
        exc = (size == 4 && a[1:0] != 2'd0) || (size == 2 && a[0]);
        val = rd;
        if (ld) begin
            raw = '0;
            for (int k = 0; k < size; k++) raw = raw | (32'(ref_mem[a + 14'(k)]) << (8 * k));
            if (exc) val = 0;
            else if (size == 1) val = sx ? 32'(signed'(raw[7:0])) : raw;
            else if (size == 2) val = sx ? 32'(signed'(raw[15:0])) : raw;
            else val = raw;
        end
        instrMEM = instr; aluOutMEM = addr; rtdataMEM = rt; pcMEM = pc;
        RegWriteMEM = rw; RegAddrMEM = ra; RegDataMEM = rd;
        @(posedge clk);
        if (st && !exc) begin
            for (int k = 0; k < size; k++) ref_mem[a + 14'(k)] = rt[8*k +: 8];
        end
        #1;
        chk({tag, ".instr"}, instrWB, instr);
        chk({tag, ".pc"}, pcWB, pc);
        chk({tag, ".we"}, 32'(RegWriteWB), 32'(rw && ra != 5'd0));
        chk({tag, ".ra"}, 32'(RegAddrWB), 32'(ra));
        chk({tag, ".data"}, RegDataWB, val);
        chk({tag, ".exc"}, 32'(addrExcWB), 32'(exc));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".instr"}, instrWB, 32'h0);
        chk({tag, ".pc"}, pcWB, 32'h0);
        chk({tag, ".we"}, 32'(RegWriteWB), 32'h0);
        chk({tag, ".ra"}, 32'(RegAddrWB), 32'h0);
        chk({tag, ".data"}, RegDataWB, 32'h0);
        chk({tag, ".exc"}, 32'(addrExcWB), 32'h0);
    endtask

    initial begin
        logic [5:0]  ops [0:8];
        logic [5:0]  op;
        logic [31:0] addr;
        ops[0] = 6'h23; ops[1] = 6'h21; ops[2] = 6'h25; ops[3] = 6'h20; ops[4] = 6'h24;
        ops[5] = 6'h2B; ops[6] = 6'h29; ops[7] = 6'h28; ops[8] = 6'h00;
        clear_model();

        // Reset state
        instrMEM = {6'h2B, 26'h0}; aluOutMEM = 32'h20; rtdataMEM = 32'h55555555;
        RegWriteMEM = 1'b1; RegAddrMEM = 5'd9; RegDataMEM = 32'h1;
        @(posedge clk); #1;
        check_all_zero("reset0");
        reset = 1'b0;
        step("rd20", mk(6'h23), 32'h20, 0, 32'h100, 1, 5'd3, 0);
        chk("reset0_store_dropped", RegDataWB, 32'h0);

        // Store then load word
        step("sw10", mk(6'h2B), 32'h10, 32'hDEADBEEF, 32'h104, 0, 5'd0, 32'h77);
        step("lw10", mk(6'h23), 32'h10, 0, 32'h108, 1, 5'd4, 32'h99);
        chk("tp_lw", RegDataWB, 32'hDEADBEEF);
        chk("tp_lw_we", 32'(RegWriteWB), 32'h1);

        // Byte merge and extension
        step("sb11", mk(6'h28), 32'h11, 32'h00000080, 32'h10C, 0, 5'd0, 0);
        step("lw10b", mk(6'h23), 32'h10, 0, 32'h110, 1, 5'd6, 0);
        chk("tp_merge", RegDataWB, 32'hDEAD80EF);
        step("lb11", mk(6'h20), 32'h11, 0, 32'h114, 1, 5'd6, 0);
        chk("tp_lb", RegDataWB, 32'hFFFFFF80);
        step("lbu11", mk(6'h24), 32'h11, 0, 32'h118, 1, 5'd6, 0);
        chk("tp_lbu", RegDataWB, 32'h00000080);
        step("lh12", mk(6'h21), 32'h12, 0, 32'h11C, 1, 5'd6, 0);
        chk("tp_lh", RegDataWB, 32'hFFFFDEAD);
        step("lhu10", mk(6'h25), 32'h10, 0, 32'h120, 1, 5'd6, 0);
        chk("tp_lhu", RegDataWB, 32'h000080EF);

        // Misalignment
        step("sw13", mk(6'h2B), 32'h13, 32'h11111111, 32'h124, 0, 5'd0, 0);
        chk("tp_sw_mis_exc", 32'(addrExcWB), 32'h1);
        step("lh11", mk(6'h21), 32'h11, 0, 32'h128, 1, 5'd7, 32'h5A5A);
        chk("tp_lh_mis_data", RegDataWB, 32'h0);
        chk("tp_lh_mis_exc", 32'(addrExcWB), 32'h1);
        step("nop_exc", 32'h0, 32'h13, 0, 32'h12C, 0, 5'd0, 0);
        chk("tp_exc_clear", 32'(addrExcWB), 32'h0);
        step("lw10c", mk(6'h23), 32'h10, 0, 32'h130, 1, 5'd8, 0);
        chk("tp_sw_mis_nowrite", RegDataWB, 32'hDEAD80EF);

        // Pass-through and register-0 guard
        step("alu5", {6'h00, 26'h0020_2A}, 32'h0, 0, 32'h134, 1, 5'd5, 32'h1234);
        chk("tp_pass_data", RegDataWB, 32'h1234);
        chk("tp_pass_we", 32'(RegWriteWB), 32'h1);
        step("alu0", {6'h00, 26'h0020_2A}, 32'h0, 0, 32'h138, 1, 5'd0, 32'h1234);
        chk("tp_r0_guard", 32'(RegWriteWB), 32'h0);

        // Wrap-around
        step("sw4000", mk(6'h2B), 32'h4000, 32'hA5A5A5A5, 32'h13C, 0, 5'd0, 0);
        step("lw0000", mk(6'h23), 32'h0, 0, 32'h140, 1, 5'd9, 0);
        chk("tp_wrap", RegDataWB, 32'hA5A5A5A5);

        // Randomized mix over a small window, with upper bits to exercise wrapping
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 6'h00) op = 6'($urandom);
            addr = ($urandom & 32'h3F) | (32'($urandom_range(0, 3)) << 14);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'hFFFF_0000;
            step("rnd", mk(op), addr, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
        end

        // Reset mid-operation with a store in MEM
        step("sw30", mk(6'h2B), 32'h30, 32'hCAFEF00D, 32'h200, 0, 5'd0, 0);
        reset = 1'b1;
        instrMEM = mk(6'h2B); aluOutMEM = 32'h34; rtdataMEM = 32'h12345678;
        pcMEM = 32'h204; RegWriteMEM = 1'b1; RegAddrMEM = 5'd3; RegDataMEM = 32'hFF;
        @(posedge clk); #1;
        check_all_zero("reset1");
        reset = 1'b0;
        clear_model();
        step("post30", mk(6'h23), 32'h30, 0, 32'h208, 1, 5'd2, 0);
        chk("tp_reset_clear30", RegDataWB, 32'h0);
        step("post34", mk(6'h23), 32'h34, 0, 32'h20C, 1, 5'd2, 0);
        chk("tp_reset_drop34", RegDataWB, 32'h0);
        step("post10", mk(6'h23), 32'h10, 0, 32'h210, 1, 5'd2, 0);
        chk("tp_reset_clear10", RegDataWB, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
